bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Shares the single simple-bus slave path (address-decoded Slave0 0x00–0x3F / Slave1 0x40–0x7F) between NUM_MGR managers.
- Round-robin arbiter with a grant held for a whole transaction; forwards the granted manager's request downstream and routes ready/rdata/resp back.
- Sits between the managers and the existing address decoder/slaves.

Parameters:
- NUM_MGR, 2, number of requesting managers (2..8).
- ADDR_W, 8, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 16, watchdog limit (used only with BUS_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  bus clock; everything is rising-edge.
- rst  in  1  reset; synchronous, active-high.
- m_valid  in  NUM_MGR  per-manager request, held high until its m_ready.
- m_wr_en  in  NUM_MGR  per-manager write(1)/read(0).
- m_addr  in  NUM_MGR*ADDR_W  packed per-manager address.
- m_wdata  in  NUM_MGR*DATA_W  packed per-manager write data.
- m_ready  out  NUM_MGR  one-cycle completion pulse to the granted manager.
- m_rdata  out  DATA_W  read data, shared; valid only with m_ready.
- m_resp  out  1  0=OK, 1=error; shared; valid only with m_ready.
- s_valid  out  1  downstream request.
- s_wr_en  out  1  downstream write enable.
- s_addr  out  ADDR_W  downstream address.
- s_wdata  out  DATA_W  downstream write data.
- s_ready  in  1  downstream completion pulse.
- s_rdata  in  DATA_W  downstream read data.
- s_resp  in  1  downstream response.
- grant_id  out  $clog2(NUM_MGR)  current/last granted manager.
- busy  out  1  high in BUSY.

Behaviour:
- FSM states:
  - IDLE: if any m_valid is high, pick the first requester searching from last_grant+1 (wrapping modulo NUM_MGR). Register grant_id and go to BUSY. Otherwise stay in IDLE.
  - BUSY: s_valid=1, and s_wr_en/s_addr/s_wdata are muxed combinationally from manager grant_id. On s_ready: m_ready[grant_id]=1 in that same cycle, m_rdata=s_rdata, m_resp=s_resp; last_grant<=grant_id; go to IDLE.
- Latency:
  - Request sampled at edge N; s_valid high from edge N+1.
  - Completion is combinational (s_ready -> m_ready, same cycle).
  - One mandatory IDLE cycle between transactions.
- Outside BUSY: s_valid=0 and m_ready=0. s_addr, s_wdata, s_wr_en, m_rdata and m_resp are driven 0 when not active.
- Reset values: state=IDLE, grant_id=0, last_grant=NUM_MGR-1 (so manager 0 wins first), busy=0, all outputs 0.
- Reset mid-BUSY: transaction abandoned, no m_ready issued, s_valid=0 from the next cycle.
- Simultaneous requests: round-robin only; no manager may be granted twice in a row while another is requesting.
- Requester dropping m_valid while granted: protocol violation. The arbiter ignores it and holds the grant until s_ready.
- s_ready while IDLE: ignored, no m_ready pulse.
- A requester that arrives while BUSY waits; it is granted at the next IDLE per round-robin.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- When defined:
  - A cycle counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT_CYCLES without s_ready: m_ready[grant_id]=1, m_resp=1, m_rdata=0, s_valid drops, FSM returns to IDLE, last_grant is updated.
  - Sticky output timeout_err (1 bit, extra port) sets on a timeout and clears only on rst.
- When undefined: no counter and no timeout_err port; BUSY waits indefinitely.

Decomposition:
- Package bus_pkg: ADDR_W/DATA_W defaults, RESP_OK=1'b0, RESP_ERR=1'b1, FSM state enum arb_state_t {IDLE, BUSY}.
- Sub-module rr_picker: purely combinational round-robin priority selector. Inputs: request vector, last_grant. Outputs: next grant index and any_req.

Test Plan:
- Single write: mgr0 writes 0x10 / 0xAAAA_BBBB, slave ready 2 cycles later -> s_valid high 1 cycle after request, s_addr=0x10, m_ready[0] pulses once with resp=0, m_ready[1] stays 0.
- Simultaneous requests after reset: mgr0 writes 0x10, mgr1 writes 0x50 / 0xCCCC_DDDD -> mgr0 served first, one IDLE cycle, then mgr1; grant_id sequence 0,1.
- Fairness: both managers continuously request 4 reads each -> grant alternates 0,1,0,1,...; per-manager completion count 4 each.
- Read return: mgr1 reads 0x50, slave returns 0xCCCC_DDDD with resp=0 -> m_rdata=0xCCCC_DDDD exactly in the m_ready[1] cycle.
- Reset mid-transaction: rst asserted 1 cycle in BUSY -> no m_ready, s_valid=0 next cycle; next grant goes to mgr0.
- Timeout (BUS_ARB_TIMEOUT_EN): slave never asserts ready -> m_ready pulses after 16 BUSY cycles with resp=1 and timeout_err=1; a later normal transaction completes with resp=0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the simple-bus manager arbiter.
// Consumed by bus_arbiter (optional watchdog macro: BUS_ARB_TIMEOUT_EN).
package bus_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;

  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin selector: first requester after i_last_grant,
// wrapping modulo NUM_MGR.
module rr_picker #(
  parameter int NUM_MGR = 2,
  parameter int IDX_W   = $clog2(NUM_MGR)
) (
  input  logic [NUM_MGR-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last_grant,
  output logic [IDX_W-1:0]   o_grant,
  output logic               o_any_req
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned; without it synthesis would infer a latch.
    o_grant   = '0;
    o_any_req = |i_req;
    // Walk from the farthest candidate to the nearest so the nearest wins.
    for (int i = NUM_MGR; i >= 1; i--) begin
      if (i_req[(int'(i_last_grant) + i) % NUM_MGR]) begin
        o_grant = IDX_W'((int'(i_last_grant) + i) % NUM_MGR);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing the downstream simple-bus path between managers;
// grant held for a whole transaction. Optional watchdog: BUS_ARB_TIMEOUT_EN.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_MGR        = 2,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_MGR-1:0]          m_valid,
  input  logic [NUM_MGR-1:0]          m_wr_en,
  input  logic [NUM_MGR*ADDR_W-1:0]   m_addr,
  input  logic [NUM_MGR*DATA_W-1:0]   m_wdata,
  output logic [NUM_MGR-1:0]          m_ready,
  output logic [DATA_W-1:0]           m_rdata,
  output logic                        m_resp,
  output logic                        s_valid,
  output logic                        s_wr_en,
  output logic [ADDR_W-1:0]           s_addr,
  output logic [DATA_W-1:0]           s_wdata,
  input  logic                        s_ready,
  input  logic [DATA_W-1:0]           s_rdata,
  input  logic                        s_resp,
  output logic [$clog2(NUM_MGR)-1:0]  grant_id,
  output logic                        busy
`ifdef BUS_ARB_TIMEOUT_EN
  ,output logic                       timeout_err
`endif
);

  localparam int IDX_W = $clog2(NUM_MGR);

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_grant_id;
  logic [IDX_W-1:0] r_last_grant;

  logic [IDX_W-1:0] w_next_grant;
  logic             w_any_req;
  logic             w_timeout;
  logic             w_done;

  rr_picker #(
    .NUM_MGR (NUM_MGR),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .i_req        (m_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_next_grant),
    .o_any_req    (w_any_req)
  );

  assign w_done = s_ready || w_timeout;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grant_id   <= '0;
      r_last_grant <= IDX_W'(NUM_MGR - 1);
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_grant_id <= w_next_grant;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          if (w_done) begin
            r_last_grant <= r_grant_id;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_tmo_cnt;
  logic             r_timeout_err;

  // Holding the counter at zero while idle is equivalent to clearing on entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt     <= '0;
      r_timeout_err <= 1'b0;
    end else if (r_state == IDLE) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
      if (w_timeout) r_timeout_err <= 1'b1;
    end
  end

  assign w_timeout   = (r_state == BUSY) && !s_ready &&
                       (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = r_timeout_err;
`else
  assign w_timeout = 1'b0;
`endif

  assign s_valid  = (r_state == BUSY);
  assign busy     = (r_state == BUSY);
  assign grant_id = r_grant_id;

  always_comb begin
    m_ready = '0;
    m_rdata = '0;
    m_resp  = RESP_OK;
    s_wr_en = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    if (r_state == BUSY) begin
      s_wr_en = m_wr_en[r_grant_id];
      s_addr  = m_addr[int'(r_grant_id)*ADDR_W +: ADDR_W];
      s_wdata = m_wdata[int'(r_grant_id)*DATA_W +: DATA_W];
      // A reset cycle abandons the transaction, so no completion escapes it.
      if (!rst) begin
        if (s_ready) begin
          m_ready[r_grant_id] = 1'b1;
          m_rdata             = s_rdata;
          m_resp              = s_resp;
        end else if (w_timeout) begin
          m_ready[r_grant_id] = 1'b1;
          m_resp              = RESP_ERR;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (2 managers); the watchdog
// steps run only when BUS_ARB_TIMEOUT_EN is defined.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_valid;
  logic [1:0]  m_wr_en;
  logic [15:0] m_addr;
  logic [63:0] m_wdata;
  logic [1:0]  m_ready;
  logic [31:0] m_rdata;
  logic        m_resp;
  logic        s_valid;
  logic        s_wr_en;
  logic [7:0]  s_addr;
  logic [31:0] s_wdata;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic        s_resp;
  logic [0:0]  grant_id;
  logic        busy;
`ifdef BUS_ARB_TIMEOUT_EN
  logic        timeout_err;
`endif

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  bus_arbiter #(
    .NUM_MGR        (2),
    .ADDR_W         (8),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m_valid  (m_valid),
    .m_wr_en  (m_wr_en),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_ready  (m_ready),
    .m_rdata  (m_rdata),
    .m_resp   (m_resp),
    .s_valid  (s_valid),
    .s_wr_en  (s_wr_en),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_ready  (s_ready),
    .s_rdata  (s_rdata),
    .s_resp   (s_resp),
    .grant_id (grant_id),
    .busy     (busy)
`ifdef BUS_ARB_TIMEOUT_EN
    ,.timeout_err (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Entered at the falling edge of the first BUSY cycle; raises s_ready after
  // wait_cyc more cycles, checks the completion, returns in the following IDLE.
  task automatic slave_ack(input string tag, input int wait_cyc, input logic [31:0] rdata,
                           input logic resp, input logic [1:0] exp_ready);
    for (int i = 0; i < wait_cyc; i++) begin
      @(negedge clk);
      check({tag, ".no_early_ready"}, 64'(m_ready), 64'(2'b00));
      check({tag, ".s_valid_held"}, 64'(s_valid), 64'(1'b1));
      check({tag, ".rdata_quiet"}, 64'(m_rdata), 64'(0));
    end
    s_rdata = rdata;
    s_resp  = resp;
    s_ready = 1'b1;
    #1;
    check({tag, ".m_ready"}, 64'(m_ready), 64'(exp_ready));
    check({tag, ".m_rdata"}, 64'(m_rdata), 64'(rdata));
    check({tag, ".m_resp"}, 64'(m_resp), 64'(resp));
    @(negedge clk);
    s_ready = 1'b0;
    s_rdata = '0;
    s_resp  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int cnt0;
    int cnt1;
    rst     = 1'b1;
    m_valid = '0;
    m_wr_en = '0;
    m_addr  = '0;
    m_wdata = '0;
    s_ready = 1'b0;
    s_rdata = '0;
    s_resp  = 1'b0;

    // Reset state
    do_reset();
    check("rst.s_valid", 64'(s_valid), 64'(0));
    check("rst.busy", 64'(busy), 64'(0));
    check("rst.grant_id", 64'(grant_id), 64'(0));
    check("rst.m_ready", 64'(m_ready), 64'(0));
    check("rst.s_addr", 64'(s_addr), 64'(0));
`ifdef BUS_ARB_TIMEOUT_EN
    check("rst.timeout_err", 64'(timeout_err), 64'(0));
`endif

    // Single write from manager 0, slave ready in the second BUSY cycle
    m_valid         = 2'b01;
    m_wr_en         = 2'b01;
    m_addr[7:0]     = 8'h10;
    m_wdata[31:0]   = 32'hAAAA_BBBB;
    #1;
    check("wr.s_valid_before_edge", 64'(s_valid), 64'(0));
    @(negedge clk);
    check("wr.s_valid", 64'(s_valid), 64'(1));
    check("wr.busy", 64'(busy), 64'(1));
    check("wr.grant_id", 64'(grant_id), 64'(0));
    check("wr.s_addr", 64'(s_addr), 64'(8'h10));
    check("wr.s_wdata", 64'(s_wdata), 64'(32'hAAAA_BBBB));
    check("wr.s_wr_en", 64'(s_wr_en), 64'(1));
    check("wr.m_ready_pre", 64'(m_ready), 64'(0));
    slave_ack("wr", 1, 32'h0, 1'b0, 2'b01);
    m_valid = 2'b00;
    #1;
    check("wr.idle_s_valid", 64'(s_valid), 64'(0));
    check("wr.idle_m_ready", 64'(m_ready), 64'(0));
    check("wr.idle_s_addr", 64'(s_addr), 64'(0));

    // Simultaneous requests after reset: manager 0 first, then manager 1
    do_reset();
    m_valid          = 2'b11;
    m_wr_en          = 2'b11;
    m_addr           = {8'h50, 8'h10};
    m_wdata          = {32'hCCCC_DDDD, 32'h1111_2222};
    @(negedge clk);
    check("sim.grant0", 64'(grant_id), 64'(0));
    check("sim.s_addr0", 64'(s_addr), 64'(8'h10));
    check("sim.s_wdata0", 64'(s_wdata), 64'(32'h1111_2222));
    slave_ack("sim0", 0, 32'h0, 1'b0, 2'b01);
    m_valid[0] = 1'b0;
    #1;
    check("sim.gap_s_valid", 64'(s_valid), 64'(0));
    check("sim.gap_busy", 64'(busy), 64'(0));
    @(negedge clk);
    check("sim.grant1", 64'(grant_id), 64'(1));
    check("sim.s_addr1", 64'(s_addr), 64'(8'h50));
    check("sim.s_wdata1", 64'(s_wdata), 64'(32'hCCCC_DDDD));
    slave_ack("sim1", 0, 32'h0, 1'b0, 2'b10);
    m_valid = 2'b00;

    // Fairness: both managers keep requesting four reads each
    cnt0    = 0;
    cnt1    = 0;
    m_valid = 2'b11;
    m_wr_en = 2'b00;
    m_addr  = {8'h60, 8'h20};
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      check($sformatf("fair.grant%0d", t), 64'(grant_id), 64'(t % 2));
      check($sformatf("fair.s_addr%0d", t), 64'(s_addr), (t % 2 == 1) ? 64'h60 : 64'h20);
      s_rdata = 32'h1000_0000 + 32'(t);
      s_ready = 1'b1;
      #1;
      if (m_ready[0]) cnt0++;
      if (m_ready[1]) cnt1++;
      check($sformatf("fair.m_rdata%0d", t), 64'(m_rdata), 64'(32'h1000_0000 + 32'(t)));
      @(negedge clk);
      s_ready = 1'b0;
      s_rdata = '0;
      if (cnt0 == 4) m_valid[0] = 1'b0;
      if (cnt1 == 4) m_valid[1] = 1'b0;
      #1;
      check($sformatf("fair.gap%0d", t), 64'(s_valid), 64'(0));
    end
    check("fair.count0", 64'(cnt0), 64'(4));
    check("fair.count1", 64'(cnt1), 64'(4));

    // Read return from manager 1
    m_valid      = 2'b10;
    m_wr_en      = 2'b00;
    m_addr[15:8] = 8'h50;
    @(negedge clk);
    check("rd.grant", 64'(grant_id), 64'(1));
    check("rd.s_wr_en", 64'(s_wr_en), 64'(0));
    check("rd.s_addr", 64'(s_addr), 64'(8'h50));
    slave_ack("rd", 1, 32'hCCCC_DDDD, 1'b0, 2'b10);
    m_valid = 2'b00;
    #1;
    check("rd.idle_rdata", 64'(m_rdata), 64'(0));

    // s_ready while idle is ignored
    s_rdata = 32'hDEAD_BEEF;
    s_ready = 1'b1;
    #1;
    check("idle_ack.m_ready", 64'(m_ready), 64'(0));
    check("idle_ack.m_rdata", 64'(m_rdata), 64'(0));
    @(negedge clk);
    s_ready = 1'b0;
    s_rdata = '0;
    check("idle_ack.busy", 64'(busy), 64'(0));
    check("idle_ack.grant_hold", 64'(grant_id), 64'(1));

    // Reset mid-transaction
    m_valid      = 2'b10;
    m_wr_en      = 2'b10;
    m_addr[15:8] = 8'h44;
    @(negedge clk);
    check("rstmid.busy", 64'(busy), 64'(1));
    check("rstmid.grant", 64'(grant_id), 64'(1));
    rst = 1'b1;
    #1;
    check("rstmid.no_ready", 64'(m_ready), 64'(0));
    @(negedge clk);
    rst         = 1'b0;
    m_valid     = 2'b11;
    m_addr[7:0] = 8'h10;
    #1;
    check("rstmid.s_valid", 64'(s_valid), 64'(0));
    check("rstmid.grant_reset", 64'(grant_id), 64'(0));
    @(negedge clk);
    check("rstmid.next_grant", 64'(grant_id), 64'(0));
    check("rstmid.s_addr", 64'(s_addr), 64'(8'h10));
    slave_ack("rstmid", 0, 32'h0, 1'b0, 2'b01);
    m_valid = 2'b00;

`ifdef BUS_ARB_TIMEOUT_EN
    // Watchdog: slave never answers, completion forced in the 16th BUSY cycle
    @(negedge clk);
    m_valid     = 2'b01;
    m_wr_en     = 2'b00;
    m_addr[7:0] = 8'h08;
    s_rdata     = 32'h1234_5678;
    @(negedge clk);
    for (int k = 1; k < 16; k++) begin
      check($sformatf("tmo.wait%0d", k), 64'(m_ready), 64'(0));
      @(negedge clk);
    end
    check("tmo.m_ready", 64'(m_ready), 64'(2'b01));
    check("tmo.m_resp", 64'(m_resp), 64'(1));
    check("tmo.m_rdata", 64'(m_rdata), 64'(0));
    check("tmo.err_not_yet", 64'(timeout_err), 64'(0));
    @(negedge clk);
    m_valid = 2'b00;
    s_rdata = '0;
    check("tmo.err_sticky", 64'(timeout_err), 64'(1));
    check("tmo.s_valid", 64'(s_valid), 64'(0));
    m_valid      = 2'b10;
    m_addr[15:8] = 8'h48;
    @(negedge clk);
    check("tmo.after_grant", 64'(grant_id), 64'(1));
    slave_ack("tmo.after", 1, 32'h0000_0042, 1'b0, 2'b10);
    m_valid = 2'b00;
    check("tmo.err_held", 64'(timeout_err), 64'(1));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
